// File: rtl/mult_tree_pipe_if.sv
// Stream bundle for mult_tree_pipe: operand side (in_*) and product side (out_*).
// master = upstream producer/downstream consumer (bench), slave = the multiplier core.
interface mult_tree_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/mult_tree_pipe.sv
// Pipelined WIDTH x WIDTH multiplier: registered partial-product rows reduced by a
// registered binary adder tree, one global advance enable, tag carried alongside.
module mult_tree_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  mult_tree_pipe_if.slave bus
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PW     = 2 * WIDTH;
  // Leaves plus every tree level except the final sum, which lives in product_q.
  localparam int NODES  = 2 * WIDTH - 2;

  // Tree nodes are stored flat; level k starts at base(k).
  function automatic int base(input int k);
    return 2 * WIDTH - 2 * (WIDTH >> k);
  endfunction

  logic                          adv;
  logic signed [PW-1:0]          ext_a;
  logic signed [PW-1:0]          tree_nxt [NODES];
  logic signed [PW-1:0]          tree_p   [NODES];
  logic        [LEVELS:0]        vld_p;
  logic        [LEVELS-1:0][TAG_W-1:0] tag_p;
  logic signed [PW-1:0]          product_q;
  logic        [TAG_W-1:0]       tag_q;

  assign adv   = !bus.out_valid || bus.out_ready;
  assign ext_a = bus.in_signed ? {{WIDTH{bus.in_a[WIDTH-1]}}, bus.in_a}
                               : {{WIDTH{1'b0}}, bus.in_a};

  // Stage 0 inputs: one shifted row per multiplier bit; the signed MSB row weighs -2^(W-1).
  for (genvar p = 0; p < WIDTH; p++) begin : g_row
    logic signed [PW-1:0] shifted;
    assign shifted = bus.in_b[p] ? (ext_a << p) : '0;
    if (p == WIDTH - 1) begin : g_msb
      assign tree_nxt[p] = bus.in_signed ? -shifted : shifted;
    end else begin : g_lsb
      assign tree_nxt[p] = shifted;
    end
  end

  // Stages 1..LEVELS-1 inputs: pairwise sums of the previous stage, modulo 2^PW.
  for (genvar k = 1; k < LEVELS; k++) begin : g_lvl
    for (genvar i = 0; i < (WIDTH >> k); i++) begin : g_node
      localparam int D = base(k) + i;
      localparam int S = base(k - 1) + 2 * i;
      assign tree_nxt[D] = tree_p[S] + tree_p[S + 1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p <= {vld_p[LEVELS-1:0], bus.in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      tree_p <= tree_nxt;
      tag_p  <= {tag_p[LEVELS-2:0], bus.in_tag};
    end
  end

  // Stage LEVELS: final sum is the architecturally visible output, so it is cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_q <= '0;
      tag_q     <= '0;
    end else if (adv) begin
      product_q <= tree_p[NODES-2] + tree_p[NODES-1];
      tag_q     <= tag_p[LEVELS-1];
    end
  end

  assign bus.in_ready    = adv;
  assign bus.out_valid   = vld_p[LEVELS];
  assign bus.out_product = product_q;
  assign bus.out_tag     = tag_q;

endmodule

// File: tb/tb_mult_tree_pipe.sv
// Randomized bench for mult_tree_pipe: a queue-based reference model checked every cycle,
// plus directed literal products, backpressure, mid-stream reset and a WIDTH=4 exhaustive sweep.
module tb_mult_tree_pipe;

  localparam int LAT   = 5;
  localparam int LAT4  = 3;

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  tag;
    int          cyc;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_tree_pipe_if #(.WIDTH(16), .TAG_W(4)) bus  ();
  mult_tree_pipe_if #(.WIDTH(4),  .TAG_W(4)) bus4 ();

  mult_tree_pipe #(.WIDTH(16), .TAG_W(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mult_tree_pipe #(.WIDTH(4),  .TAG_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: interpret each operand per mode, multiply exactly, keep 2*w bits.
  function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
    longint x, y, p;
    logic [63:0] mask;
    x = longint'(a);
    y = longint'(b);
    if (s && ((a >> (w - 1)) & 32'd1) != 0) x = x - (longint'(1) << w);
    if (s && ((b >> (w - 1)) & 32'd1) != 0) y = y - (longint'(1) << w);
    p = x * y;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  function automatic logic [15:0] pick16();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- scoreboard for WIDTH=16 ----------------
  exp_t        q16[$];
  exp_t        e16;
  int          cyc16 = 0;
  int          stalls16 = 0;
  bit          hold16 = 0;
  logic [31:0] prev_prod;
  logic [3:0]  prev_tag;

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      hold16 = 0;
    end else begin
      chk("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (hold16) begin
        chk("hold_valid",   64'(bus.out_valid), 64'd1);
        chk("hold_product", 64'(bus.out_product), 64'(prev_prod));
        chk("hold_tag",     64'(bus.out_tag), 64'(prev_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q16.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious16: got product %0h, expected no result", bus.out_product);
        end else begin
          e16 = q16.pop_front();
          chk("product16", 64'(bus.out_product), 64'(e16.prod));
          chk("tag16",     64'(bus.out_tag), 64'(e16.tag));
          chk("latency16", 64'(cyc16 - e16.cyc), 64'(LAT + stalls16 - e16.stalls));
        end
      end
      if (bus.out_valid && !bus.out_ready) stalls16++;
      if (bus.in_valid && bus.in_ready) begin
        e16.prod   = 32'(ref_prod(bus.in_signed, 32'(bus.in_a), 32'(bus.in_b), 16));
        e16.tag    = bus.in_tag;
        e16.cyc    = cyc16;
        e16.stalls = stalls16;
        q16.push_back(e16);
      end
      hold16    = bus.out_valid && !bus.out_ready;
      prev_prod = bus.out_product;
      prev_tag  = bus.out_tag;
      cyc16++;
    end
  end

  // ---------------- scoreboard for WIDTH=4 ----------------
  exp_t q4[$];
  exp_t e4;
  int   cyc4 = 0;

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else begin
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious4: got product %0h, expected no result", bus4.out_product);
        end else begin
          e4 = q4.pop_front();
          chk("product4", 64'(bus4.out_product), 64'(e4.prod));
          chk("tag4",     64'(bus4.out_tag), 64'(e4.tag));
          chk("latency4", 64'(cyc4 - e4.cyc), 64'(LAT4));
        end
      end
      if (bus4.in_valid && bus4.in_ready) begin
        e4.prod   = 32'(ref_prod(bus4.in_signed, 32'(bus4.in_a), 32'(bus4.in_b), 4));
        e4.tag    = bus4.in_tag;
        e4.cyc    = cyc4;
        e4.stalls = 0;
        q4.push_back(e4);
      end
      cyc4++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_rand(input bit v);
    bus.in_valid  = v;
    bus.in_signed = 1'($urandom);
    bus.in_a      = pick16();
    bus.in_b      = pick16();
    bus.in_tag    = 4'($urandom);
  endtask

  task automatic single(input bit s, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] t, input logic [31:0] exp);
    int n;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = t;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && n < 20);
    chk("single_latency", 64'(n), 64'(LAT));
    chk("single_product", 64'(bus.out_product), 64'(exp));
    chk("single_tag",     64'(bus.out_tag), 64'(t));
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_signed  = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_signed = 1'b0;
    bus4.in_a      = '0;
    bus4.in_b      = '0;
    bus4.in_tag    = '0;
    bus4.out_ready = 1'b1;

    #2;
    chk("reset_out_valid",   64'(bus.out_valid), 64'd0);
    chk("reset_out_product", 64'(bus.out_product), 64'd0);
    chk("reset_out_tag",     64'(bus.out_tag), 64'd0);
    chk("reset_in_ready",    64'(bus.in_ready), 64'd1);
    chk("reset_out_valid4",  64'(bus4.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    single(1'b0, 16'hFFFF, 16'hFFFF, 4'h5, 32'hFFFE0001);
    single(1'b1, 16'hFFFF, 16'h0002, 4'hA, 32'hFFFFFFFE);
    single(1'b0, 16'hFFFF, 16'h0002, 4'h3, 32'h0001FFFE);
    single(1'b1, 16'h8000, 16'h8000, 4'hC, 32'h40000000);

    // Full-rate random stream.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 drive_rand(1'b1);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);

    // Fill the pipe, then stall the output for 3 cycles.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 drive_rand(1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      drive_rand(1'b1);
      #1;
      chk("stall_in_ready",  64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 drive_rand(1'b1);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);

    // Random valid and random backpressure.
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      drive_rand(($urandom % 4) != 0);
      bus.out_ready = ($urandom % 3) != 0;
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 drive_rand(1'b1);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midreset_out_valid",   64'(bus.out_valid), 64'd0);
    chk("midreset_out_product", 64'(bus.out_product), 64'd0);
    chk("midreset_out_tag",     64'(bus.out_tag), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    single(1'b1, 16'h7FFF, 16'h8000, 4'h9, 32'hC0008000);
    repeat (8) @(posedge clk);

    // WIDTH=4: every operand pair in both modes.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = 9'(i);
      @(posedge clk);
      #1;
      bus4.in_valid  = 1'b1;
      bus4.in_signed = idx[8];
      bus4.in_a      = idx[7:4];
      bus4.in_b      = idx[3:0];
      bus4.in_tag    = idx[7:4] ^ idx[3:0];
    end
    @(posedge clk);
    #1 bus4.in_valid = 1'b0;
    repeat (8) @(posedge clk);

    #1;
    chk("drained16", 64'(q16.size()), 64'd0);
    chk("drained4",  64'(q4.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
